target_acquisition_unit: RTL and testbench
==========================================

Name: target_acquisition_unit

Overview:
- Radar ping/echo front end that sits directly upstream of the weapons control unit.
- Emits radar pulses while scanning, times the echo return and measures target distance in cycles.
- Asserts target_locked after LOCK_COUNT consecutive echoes, then periodically re-verifies the lock.
- target_locked drives the weapons control unit's target_locked input directly.

Parameters:
- LISTEN_TIMEOUT, 8: maximum LISTEN cycles to wait for an echo; legal range 1..255.
- LOCK_COUNT, 2: consecutive echoes needed to acquire lock; legal range 1..15.
- LOCK_HOLD, 10: cycles spent in LOCKED before a re-verify ping; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- scan_for_target  in  1  level; scanning is enabled while high.
- radar_echo  in  1  echo detect, sampled on clk.
- pulse_emitted  out  1  high for exactly one cycle per ping.
- target_locked  out  1  lock indication to the weapons control unit.
- distance  out  8  last measured echo delay in LISTEN cycles.
- TAU_state  out  2  current FSM state.

Behaviour:
- All outputs are registered. Reset values: TAU_state=IDLE(00), pulse_emitted=0, target_locked=0, distance=0. Internal timer, hit counter and track flag are also cleared to 0.
- rst is synchronous and has priority over everything. Asserting it mid-operation returns the block to the reset state on the next edge.
- IDLE (00):
  - pulse_emitted=0.
  - If scan_for_target=1 at an edge, go to EMIT.
- EMIT (01):
  - pulse_emitted=1 for this single cycle only.
  - timer cleared to 0; unconditionally go to LISTEN on the next edge.
- LISTEN (10): at each edge, in this order:
  - radar_echo=1: distance <= timer+1 and hit counter increments.
    - If in track mode, or the incremented hit count equals LOCK_COUNT: go to LOCKED, set target_locked=1 and clear the LOCKED hold counter.
    - Otherwise go to EMIT.
  - No echo and timer+1 == LISTEN_TIMEOUT: miss.
    - hits=0, track flag=0, target_locked=0, distance unchanged.
    - Go to EMIT if scan_for_target=1, else IDLE.
  - Otherwise timer increments.
  - Consequently, an echo sampled on the k-th LISTEN edge gives distance=k, with 1 <= k <= LISTEN_TIMEOUT.
- LOCKED (11):
  - target_locked stays 1 and the hold counter increments each cycle.
  - When the hold count reaches LOCK_HOLD, set track flag=1 and go to EMIT (re-verify ping).
  - target_locked stays 1 through the EMIT/LISTEN re-verify cycles.
  - In track mode a single echo returns the block to LOCKED, and hits saturate at LOCK_COUNT.
- Simultaneous events:
  - An echo on the same edge as the timeout counts as an echo; echo wins.
  - radar_echo outside LISTEN is ignored.
- scan_for_target=0 sampled at any edge in EMIT, LISTEN or LOCKED:
  - Next state is IDLE.
  - target_locked, hits, timer and track flag are cleared; distance is retained.
  - This has priority over echo and timeout handling but not over rst.
- Width rules: hit counter is 4 bits; timer and hold counter are 8 bits; no wrap-around is possible within the legal parameter ranges.

Test Plan (default parameters):
- Acquisition: rst for 2 cycles, then scan_for_target=1 with radar_echo pulsed on the 3rd LISTEN edge of two consecutive pings.
  - Required: two one-cycle pulse_emitted pulses and distance=3.
  - target_locked rises on the edge of the second echo with TAU_state=11.
- Timeout: scan_for_target=1, radar_echo held 0.
  - Required: each ping is followed by exactly 8 LISTEN cycles, then EMIT again.
  - target_locked=0 throughout and distance stays 0.
- Lock then re-verify hit: after acquisition, wait 10 cycles in LOCKED.
  - Required: EMIT with pulse_emitted=1 and target_locked still 1.
  - An echo on LISTEN edge 5 returns the block to 11 with distance=5.
- Lock then re-verify miss: after acquisition, no echo during re-verify.
  - Required: target_locked falls on the 8th LISTEN edge and the next state is EMIT.
  - Acquisition then needs 2 fresh echoes.
- Boundary and aborts:
  - An echo on the 8th LISTEN edge is accepted with distance=8.
  - Dropping scan_for_target in LISTEN gives IDLE next edge with target_locked=0.
  - rst asserted mid-LISTEN gives all outputs at reset values on the next edge.

Source files
------------

// File: rtl/target_acquisition_unit.sv
// Radar ping/echo front end. It pings while scanning, times the echo return,
// and raises target_locked after LOCK_COUNT consecutive echoes. While locked it
// periodically re-pings to confirm the target is still there.
//
// Ports:
//   clk             system clock, rising edge
//   rst             synchronous active-high reset
//   scan_for_target level, scanning enabled while high
//   radar_echo      echo detect, sampled only in LISTEN
//   pulse_emitted   one-cycle ping strobe (high while in EMIT)
//   target_locked   lock indication to the weapons control unit
//   distance        last measured echo delay in LISTEN cycles
//   TAU_state       current FSM state (00 IDLE, 01 EMIT, 10 LISTEN, 11 LOCKED)
module target_acquisition_unit #(
   parameter int unsigned LISTEN_TIMEOUT = 8,
   parameter int unsigned LOCK_COUNT     = 2,
   parameter int unsigned LOCK_HOLD      = 10
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       scan_for_target,
   input  logic       radar_echo,
   output logic       pulse_emitted,
   output logic       target_locked,
   output logic [7:0] distance,
   output logic [1:0] TAU_state
);

   localparam int unsigned CNT_W = 8;
   localparam int unsigned HIT_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_EMIT   = 2'b01,
      ST_LISTEN = 2'b10,
      ST_LOCKED = 2'b11
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   timer;
   logic [CNT_W-1:0]   hold;
   logic [HIT_W-1:0]   hits;
   logic               track;

   logic [CNT_W-1:0]   timer_inc;
   logic [CNT_W-1:0]   hold_inc;
   logic [HIT_W-1:0]   hits_inc;
   logic [HIT_W-1:0]   hits_sat;
   logic               lock_hit;

   // Incremented counters; hits saturate once lock has been reached.
   assign timer_inc = timer + CNT_W'(1);
   assign hold_inc  = hold + CNT_W'(1);
   assign hits_inc  = hits + HIT_W'(1);
   assign hits_sat  = (hits == HIT_W'(LOCK_COUNT)) ? hits : hits_inc;
   assign lock_hit  = track || (hits_inc == HIT_W'(LOCK_COUNT));

   assign TAU_state = state;

   // State machine with registered outputs; pulse_emitted is raised on entry to EMIT.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= ST_IDLE;
         pulse_emitted <= 1'b0;
         target_locked <= 1'b0;
         distance      <= '0;
         timer         <= '0;
         hold          <= '0;
         hits          <= '0;
         track         <= 1'b0;
      end else begin
         pulse_emitted <= 1'b0;
         if (state != ST_IDLE && !scan_for_target) begin
            // Scan dropped: abort to IDLE, keep the last distance.
            state         <= ST_IDLE;
            target_locked <= 1'b0;
            hits          <= '0;
            timer         <= '0;
            track         <= 1'b0;
         end else begin
            case (state)
               ST_IDLE: begin
                  if (scan_for_target) begin
                     state         <= ST_EMIT;
                     pulse_emitted <= 1'b1;
                  end
               end
               ST_EMIT: begin
                  timer <= '0;
                  state <= ST_LISTEN;
               end
               ST_LISTEN: begin
                  if (radar_echo) begin
                     // Echo wins over a coincident timeout.
                     distance <= timer_inc;
                     hits     <= hits_sat;
                     if (lock_hit) begin
                        state         <= ST_LOCKED;
                        target_locked <= 1'b1;
                        hold          <= '0;
                     end else begin
                        state         <= ST_EMIT;
                        pulse_emitted <= 1'b1;
                     end
                  end else if (timer_inc == CNT_W'(LISTEN_TIMEOUT)) begin
                     // Miss: lose any lock and start acquisition over.
                     hits          <= '0;
                     track         <= 1'b0;
                     target_locked <= 1'b0;
                     state         <= ST_EMIT;
                     pulse_emitted <= 1'b1;
                  end else begin
                     timer <= timer_inc;
                  end
               end
               ST_LOCKED: begin
                  hold <= hold_inc;
                  if (hold_inc == CNT_W'(LOCK_HOLD)) begin
                     track         <= 1'b1;
                     state         <= ST_EMIT;
                     pulse_emitted <= 1'b1;
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_target_acquisition_unit.sv
// Directed bench for target_acquisition_unit with default parameters.
module tb_target_acquisition_unit;

   logic       clk = 1'b0;
   logic       rst;
   logic       scan_for_target;
   logic       radar_echo;
   logic       pulse_emitted;
   logic       target_locked;
   logic [7:0] distance;
   logic [1:0] TAU_state;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   localparam logic [1:0] S_IDLE = 2'b00, S_EMIT = 2'b01, S_LISTEN = 2'b10, S_LOCKED = 2'b11;

   target_acquisition_unit dut (
      .clk             (clk),
      .rst             (rst),
      .scan_for_target (scan_for_target),
      .radar_echo      (radar_echo),
      .pulse_emitted   (pulse_emitted),
      .target_locked   (target_locked),
      .distance        (distance),
      .TAU_state       (TAU_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic expect_all(input string tag, input int st, input int pe, input int tl, input int d);
      check({tag, ".state"},  int'(TAU_state), st);
      check({tag, ".pulse"},  int'(pulse_emitted), pe);
      check({tag, ".locked"}, int'(target_locked), tl);
      check({tag, ".dist"},   int'(distance), d);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; scan_for_target = 1'b0; radar_echo = 1'b0;
      ticks(2);
      expect_all("reset", S_IDLE, 0, 0, 0);

      // Idle ignores echo while not scanning.
      rst = 1'b0; radar_echo = 1'b1;
      tick();
      expect_all("idle_echo", S_IDLE, 0, 0, 0);
      radar_echo = 1'b0;

      // Acquisition: echoes on LISTEN edge 3 of two pings.
      scan_for_target = 1'b1;
      tick();
      expect_all("acq_emit1", S_EMIT, 1, 0, 0);
      tick();
      expect_all("acq_listen1", S_LISTEN, 0, 0, 0);
      ticks(2);
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("acq_echo1", S_EMIT, 1, 0, 3);
      tick();
      expect_all("acq_listen2", S_LISTEN, 0, 0, 3);
      ticks(2);
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("acq_lock", S_LOCKED, 0, 1, 3);

      // Re-verify hit: 10 cycles held, then ping, echo on edge 5.
      ticks(9);
      expect_all("hold9", S_LOCKED, 0, 1, 3);
      tick();
      expect_all("rv_emit", S_EMIT, 1, 1, 3);
      tick();
      expect_all("rv_listen", S_LISTEN, 0, 1, 3);
      ticks(4);
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("rv_hit", S_LOCKED, 0, 1, 5);

      // Re-verify miss: lock drops on LISTEN edge 8.
      ticks(10);
      expect_all("rv2_emit", S_EMIT, 1, 1, 5);
      tick();
      ticks(7);
      expect_all("rv2_edge7", S_LISTEN, 0, 1, 5);
      tick();
      expect_all("rv2_miss", S_EMIT, 1, 0, 5);

      // Fresh acquisition needs two echoes; second on edge 8 (boundary).
      tick();
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("reacq1", S_EMIT, 1, 0, 1);
      tick();
      ticks(7);
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("reacq_edge8", S_LOCKED, 0, 1, 8);

      // Drop scan while locked.
      scan_for_target = 1'b0;
      tick();
      expect_all("abort_locked", S_IDLE, 0, 0, 8);

      // Reset, then timeout with no echo over two pings.
      rst = 1'b1;
      tick();
      expect_all("reset2", S_IDLE, 0, 0, 0);
      rst = 1'b0; scan_for_target = 1'b1;
      for (int p = 0; p < 2; p++) begin
         tick();
         expect_all("to_emit", S_EMIT, 1, 0, 0);
         for (int k = 1; k <= 8; k++) begin
            tick();
            check("to_listen", int'(TAU_state), S_LISTEN);
            check("to_locked", int'(target_locked), 0);
         end
      end
      tick();
      expect_all("to_done", S_EMIT, 1, 0, 0);

      // Lock on edge-1 echoes, then drop scan during re-verify LISTEN with an echo present.
      tick();
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("q_echo1", S_EMIT, 1, 0, 1);
      tick();
      radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("q_lock", S_LOCKED, 0, 1, 1);
      ticks(10);
      tick();
      tick();
      expect_all("q_rv_listen", S_LISTEN, 0, 1, 1);
      scan_for_target = 1'b0; radar_echo = 1'b1;
      tick();
      radar_echo = 1'b0;
      expect_all("abort_listen", S_IDLE, 0, 0, 1);

      // Reset mid-LISTEN.
      scan_for_target = 1'b1;
      ticks(3);
      check("pre_rst_state", int'(TAU_state), S_LISTEN);
      rst = 1'b1;
      tick();
      expect_all("rst_listen", S_IDLE, 0, 0, 0);
      rst = 1'b0; scan_for_target = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
